// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer.
//   aes_ctrl_state_t : sequencer FSM states
//   aes_nr(k)        : round count for a key width (10 / 12 / 14)
//   AES_RND_W        : width of the round-key index
package aes_pkg;

    localparam int AES_RND_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KEYFWD,
        ST_ROUND,
        ST_DONE
    } aes_ctrl_state_t;

    function automatic int aes_nr(input int k);
        return k / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_rnd_counter.sv
// Loadable up/down round counter.
// Ports:
//   clk, reset : core clock, synchronous active-high reset (clears cnt)
//   ld, ld_val : load cnt with ld_val (wins over en)
//   en, up     : step cnt by +1 (up=1) or -1 (up=0)
//   tgt        : value term compares against
//   cnt        : current count (registered)
//   term       : cnt == tgt
module aes_rnd_counter
    import aes_pkg::*;
#(
    parameter int W = AES_RND_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] tgt,
    output logic [W-1:0] cnt,
    output logic         term
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en) begin
            cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
        end
    end

    assign term = (cnt == tgt);

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES core. Detects the end of a load
// frame, picks encrypt/decrypt, runs the forward key-expansion pass for
// decrypt, then steps the datapath through every round and raises done.
// Ports:
//   clk, reset   : core clock, synchronous active-high reset
//   load         : frame shifting in; falling edge starts an operation,
//                  rising during a run aborts it
//   dir          : 1 = decrypt (only used when INV = 2)
//   rnd_en       : datapath state update enable
//   key_en       : round-key register update enable
//   key_dir      : 0 = forward key expansion, 1 = inverse
//   inv          : direction of the current operation
//   first / last : initial AddRoundKey-only cycle / final round
//   round        : current round-key index
//   done         : result valid, held until the next frame
//   err          : (AES_ROUND_CTRL_ERR_EN only) set on abort, cleared at
//                  the next operation start
// Parameters: K = 128/192/256 key width, INV = 0 enc / 1 dec / 2 runtime.
// All outputs are registered.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int K   = 256,
    parameter int INV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 dir,
    output logic                 rnd_en,
    output logic                 key_en,
    output logic                 key_dir,
    output logic                 inv,
    output logic                 first,
    output logic                 last,
    output logic [AES_RND_W-1:0] round,
    output logic                 done
`ifdef AES_ROUND_CTRL_ERR_EN
    ,
    output logic                 err
`endif
);

    generate
        if (K != 128 && K != 192 && K != 256) begin : g_bad_k
            $error("aes_round_ctrl: K must be 128, 192 or 256");
        end
        if (INV < 0 || INV > 2) begin : g_bad_inv
            $error("aes_round_ctrl: INV must be 0, 1 or 2");
        end
    endgenerate

    localparam logic [AES_RND_W-1:0] NR = AES_RND_W'(aes_nr(K));

    aes_ctrl_state_t state, nstate;

    logic                 start, abort, dec_sel;
    logic                 cnt_ld, cnt_en, cnt_up, cnt_term;
    logic [AES_RND_W-1:0] cnt_ld_val, cnt_tgt, cnt_nxt;
    logic                 inv_d, rnd_en_d, key_en_d, key_dir_d;
    logic                 first_d, last_d, done_d;

    generate
        if (INV == 0) begin : g_enc_only
            assign dec_sel = 1'b0;
        end else if (INV == 1) begin : g_dec_only
            assign dec_sel = 1'b1;
        end else begin : g_dir_sel
            assign dec_sel = dir;
        end
    endgenerate

    assign start = (state == ST_LOAD) && !load;
    assign abort = load && ((state == ST_KEYFWD) || (state == ST_ROUND));

    // KEYFWD stops one short of Nr; ROUND ends at Nr (enc) or 0 (dec).
    assign cnt_tgt = (state == ST_KEYFWD) ? NR - 1'b1 : (inv ? '0 : NR);

    // The counter register is the round output itself.
    aes_rnd_counter #(.W(AES_RND_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_val),
        .en     (cnt_en),
        .up     (cnt_up),
        .tgt    (cnt_tgt),
        .cnt    (round),
        .term   (cnt_term)
    );

    // State register plus the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            rnd_en  <= 1'b0;
            key_en  <= 1'b0;
            key_dir <= 1'b0;
            inv     <= 1'b0;
            first   <= 1'b0;
            last    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nstate;
            rnd_en  <= rnd_en_d;
            key_en  <= key_en_d;
            key_dir <= key_dir_d;
            inv     <= inv_d;
            first   <= first_d;
            last    <= last_d;
            done    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:   if (load) nstate = ST_LOAD;
            ST_LOAD:   if (!load) nstate = dec_sel ? ST_KEYFWD : ST_ROUND;
            ST_KEYFWD: if (abort) nstate = ST_LOAD;
                       else if (cnt_term) nstate = ST_ROUND;
            ST_ROUND:  if (abort) nstate = ST_LOAD;
                       else if (cnt_term) nstate = ST_DONE;
            ST_DONE:   if (load) nstate = ST_LOAD;
            default:   nstate = ST_IDLE;
        endcase
    end

    // Counter control and next values of the registered outputs. Outputs
    // are derived from the state being entered so they line up with it.
    always_comb begin
        cnt_ld     = 1'b0;
        cnt_ld_val = '0;
        cnt_en     = 1'b0;
        cnt_up     = 1'b1;
        inv_d      = inv;
        if (nstate == ST_LOAD) begin
            // Any entry into LOAD (abort or new frame) clears the index.
            cnt_ld = 1'b1;
        end else if (start) begin
            cnt_ld = 1'b1;
            inv_d  = dec_sel;
        end else if (state == ST_KEYFWD) begin
            if (cnt_term) begin
                // Expansion complete: decrypt rounds start from key Nr.
                cnt_ld     = 1'b1;
                cnt_ld_val = NR;
            end else begin
                cnt_en = 1'b1;
            end
        end else if ((state == ST_ROUND) && !cnt_term) begin
            cnt_en = 1'b1;
            cnt_up = !inv;
        end

        if (cnt_ld) begin
            cnt_nxt = cnt_ld_val;
        end else if (cnt_en) begin
            cnt_nxt = cnt_up ? round + 1'b1 : round - 1'b1;
        end else begin
            cnt_nxt = round;
        end

        rnd_en_d  = (nstate == ST_ROUND);
        key_en_d  = rnd_en_d || (nstate == ST_KEYFWD);
        key_dir_d = rnd_en_d && inv_d;
        first_d   = rnd_en_d && (state != ST_ROUND);
        last_d    = rnd_en_d && (cnt_nxt == (inv_d ? '0 : NR));
        done_d    = (nstate == ST_DONE);
    end

`ifdef AES_ROUND_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (abort) begin
            err <= 1'b1;
        end else if (start) begin
            err <= 1'b0;
        end
    end
`endif

    // The index must stay within 0..Nr.
    a_rnd_max: assert property (@(posedge clk) disable iff (reset) round <= NR);
    a_no_up_wrap: assert property (@(posedge clk) disable iff (reset)
        !(cnt_en && cnt_up && (round == NR)));
    a_no_dn_wrap: assert property (@(posedge clk) disable iff (reset)
        !(cnt_en && !cnt_up && (round == '0)));

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES core. It sits between the SPI front end and the round/key-schedule datapath. It detects the end of a `load` frame, selects encrypt or decrypt, and steps the datapath through every round, including the forward key-expansion pass that decryption needs. It raises `done` so the SPI side can shift the result out.

## Interface
- `K`, 256, key width; legal values 128, 192, 256; any other value is an elaboration error.
- `INV`, 2, direction mode: 0 = encrypt only, 1 = decrypt only, 2 = runtime select via `dir`.
- `clk`  in  1  core clock.
- `reset`  in  1  reset; synchronous and active-high.
- `load`  in  1  high while the SPI frame is shifting in; a high-to-low transition starts an operation.
- `dir`  in  1  bit 0 of the direction byte; 1 = decrypt; used only when INV=2.
- `rnd_en`  out  1  datapath state register update enable.
- `key_en`  out  1  round-key register update enable.
- `key_dir`  out  1  0 = forward key expansion, 1 = inverse expansion.
- `inv`  out  1  datapath direction for the current operation.
- `first`  out  1  initial AddRoundKey-only cycle.
- `last`  out  1  final round (no MixColumns / InvMixColumns).
- `round`  out  4  current round-key index.
- `done`  out  1  result valid; held until the next frame.

## Operation
- Nr = K/32 + 6, giving 10, 12 or 14.
- **States:** IDLE, LOAD, KEYFWD, ROUND, DONE.
- **IDLE**
  - `load`=1 → LOAD.
- **LOAD**
  - `load`=0 → start.
  - `inv` is latched: INV=0 gives 0, INV=1 gives 1, INV=2 gives `dir`.
  - If encrypting: → ROUND with `round`=0.
  - If decrypting: → KEYFWD with `round`=0.
- **KEYFWD** (decrypt only)
  - Outputs: `key_en`=1, `key_dir`=0, `rnd_en`=0.
  - `round` increments every cycle.
  - When `round`=Nr-1: → ROUND with `round`=Nr.
- **ROUND**
  - Outputs: `rnd_en`=1, `key_en`=1.
  - `key_dir`=`inv`.
  - Encrypt: `round` counts 0→Nr.
  - Decrypt: `round` counts Nr→0.
  - `first` is high on the first ROUND cycle (round 0 for encrypt, round Nr for decrypt).
  - `last` is high on the terminal ROUND cycle (round Nr for encrypt, round 0 for decrypt).
  - After the terminal cycle: → DONE.
- **DONE**
  - `done`=1; all enables are 0.
  - `round` and `inv` hold their values.
  - `load`=1 → LOAD, and `done` drops in that same cycle.
- **Abort:** `load`=1 in KEYFWD or ROUND → LOAD. Enables drop in the next cycle and the counter clears to 0.
- `round` never wraps. Counting beyond Nr or below 0 is unreachable by construction; assertions cover it.

## Timing
- All outputs are registered.
- `reset` values: state IDLE; all outputs 0.
- `reset` overrides everything, including a reset arriving mid-operation.
- Let E0 be the edge that samples `load`=0 in LOAD.
- **Encrypt:** ROUND occupies the cycles after edges E0 … E0+Nr. `done`=1 after edge E0+Nr+1, i.e. latency Nr+1 edges.
- **Decrypt:**
  - KEYFWD occupies the cycles after edges E0 … E0+Nr-1.
  - ROUND occupies the cycles after edges E0+Nr … E0+2Nr.
  - `done`=1 after edge E0+2Nr+1.
- `dir` is sampled only at E0; later changes are ignored.
- `load` and `dir` are already synchronous to `clk`; the block does not synchronize them.

## Configuration
- `AES_ROUND_CTRL_ERR_EN`: adds an `err` output (1 bit, reset 0).
  - `err` is set when an abort occurs.
  - `err` is cleared at the next E0.
- Without the macro: no `err` port, and abort behaviour is otherwise identical.

## Structure
- **aes_pkg contains:**
  - the state enum `aes_ctrl_state_t`;
  - the function `aes_nr(K)`;
  - the constant `AES_RND_W = 4`.
- **Sub-module `aes_rnd_counter`:** loadable up/down counter.
  - Inputs: `clk`, `reset`, `ld`, `ld_val`, `en`, `up`.
  - Outputs: `cnt`, and `term`, which compares against a target value.
- The FSM lives in `aes_round_ctrl`.

## Test plan
- **K=128, INV=0:** `load` 1→0 → `first` with `round`=0 on cycle 1, `last` with `round`=10 on cycle 11, `done`=1 on cycle 12; `key_en`/`rnd_en` high for exactly 11 cycles.
- **K=256, INV=2, `dir`=1:** 14 KEYFWD cycles with `rnd_en`=0 and `round` 0→13; then ROUND with `round` 14→0 and `key_dir`=1; `done` after 29 edges.
- **K=192, INV=2, `dir`=0:** `inv`=0 and `last` at `round`=12. Toggling `dir` mid-run has no effect.
- **Abort:** raise `load` at ROUND `round`=5 → next cycle LOAD, enables 0, `round`=0. Drop `load` again → a clean full run. With `AES_ROUND_CTRL_ERR_EN`: `err`=1 through LOAD, cleared at E0.
- **Reset in KEYFWD:** all outputs 0 on the next cycle, state IDLE. `load` low while in IDLE → no activity.
- **Back-to-back frames:** DONE held for 20 cycles with `done`=1, then `load`=1 → `done`=0 in the same cycle, then a second encrypt run matches the first-run timing.
